// File: rtl/regfile_rename_pkg.sv
// Shared register-file constants and ROB tag helpers, common to the ROB, Decoder and regfile.
package regfile_rename_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned REG_WIDTH  = 5;
  localparam int unsigned TAG_WIDTH  = 4;
  localparam int unsigned NUM_REGS   = 1 << REG_WIDTH;
  localparam int unsigned CNT_WIDTH  = REG_WIDTH + 1;

  // MSB set means "no pending producer"; any MSB-clear value is a live ROB tag.
  localparam logic [TAG_WIDTH-1:0] TAG_FREE = {1'b1, {(TAG_WIDTH-1){1'b0}}};

  function automatic logic tag_is_free(input logic [TAG_WIDTH-1:0] tag);
    return tag == TAG_FREE;
  endfunction

  function automatic logic tag_is_valid(input logic [TAG_WIDTH-1:0] tag);
    return ~tag[TAG_WIDTH-1];
  endfunction

endpackage

// File: rtl/regfile_lookup.sv
// One source-operand read port: returns committed data or the pending producer tag,
// with a bypass of a same-cycle commit that retires the awaited producer.
module regfile_lookup
  import regfile_rename_pkg::*;
(
  input  logic [REG_WIDTH-1:0]  i_name,
  input  logic [DATA_WIDTH-1:0] i_stored_data,
  input  logic [TAG_WIDTH-1:0]  i_stored_tag,
  input  logic                  i_commit_en,
  input  logic [REG_WIDTH-1:0]  i_commit_reg,
  input  logic [DATA_WIDTH-1:0] i_commit_data,
  input  logic [TAG_WIDTH-1:0]  i_commit_tag,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic [DATA_WIDTH-1:0] o_data
);

  always_comb begin
    o_tag  = TAG_FREE;
    o_data = '0;
    if (i_name != '0) begin
      if (i_commit_en && (i_name == i_commit_reg) && (i_stored_tag == i_commit_tag)) begin
        o_data = i_commit_data;
      end else if (tag_is_free(i_stored_tag)) begin
        o_data = i_stored_data;
      end else begin
        o_tag = i_stored_tag;
      end
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags, commit bypass and flush.
module regfile_rename
  import regfile_rename_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rename_en,
  input  logic [REG_WIDTH-1:0]  i_rename_reg,
  input  logic [TAG_WIDTH-1:0]  i_rename_tag,
  input  logic [REG_WIDTH-1:0]  i_rs1_name,
  input  logic [REG_WIDTH-1:0]  i_rs2_name,
  output logic [TAG_WIDTH-1:0]  o_rs1_tag,
  output logic [TAG_WIDTH-1:0]  o_rs2_tag,
  output logic [DATA_WIDTH-1:0] o_rs1_data,
  output logic [DATA_WIDTH-1:0] o_rs2_data,
  input  logic                  i_commit_en,
  input  logic [REG_WIDTH-1:0]  i_commit_reg,
  input  logic [DATA_WIDTH-1:0] i_commit_data,
  input  logic [TAG_WIDTH-1:0]  i_commit_tag,
  input  logic                  i_flush,
  output logic [CNT_WIDTH-1:0]  o_pending_cnt
);

  logic [DATA_WIDTH-1:0] r_data [NUM_REGS];
  logic [TAG_WIDTH-1:0]  r_tag  [NUM_REGS];
  logic [CNT_WIDTH-1:0]  r_pending_cnt;

  logic w_commit_wr;
  logic w_commit_clr;
  logic w_rename_wr;
  logic w_inc;
  logic w_dec;

  assign w_commit_wr  = i_commit_en && (i_commit_reg != '0);
  // A stale commit (tag mismatch) writes data but must not free a younger rename.
  assign w_commit_clr = w_commit_wr && (r_tag[i_commit_reg] == i_commit_tag) &&
                        !tag_is_free(r_tag[i_commit_reg]);
  assign w_rename_wr  = i_rename_en && (i_rename_reg != '0) && !i_flush;
  assign w_inc        = w_rename_wr && tag_is_free(r_tag[i_rename_reg]);
  assign w_dec        = w_commit_clr && !(w_rename_wr && (i_rename_reg == i_commit_reg));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= TAG_FREE;
      end
    end else begin
      if (w_commit_wr) begin
        r_data[i_commit_reg] <= i_commit_data;
      end
      if (i_flush) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          r_tag[i] <= TAG_FREE;
        end
      end else begin
        if (w_commit_clr) begin
          r_tag[i_commit_reg] <= TAG_FREE;
        end
        // Later assignment wins: a same-cycle rename overrides the clear.
        if (w_rename_wr) begin
          r_tag[i_rename_reg] <= i_rename_tag;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending_cnt <= '0;
    end else if (i_flush) begin
      r_pending_cnt <= '0;
    end else begin
      r_pending_cnt <= r_pending_cnt + CNT_WIDTH'(w_inc) - CNT_WIDTH'(w_dec);
    end
  end

  assign o_pending_cnt = r_pending_cnt;

  regfile_lookup u_lookup_rs1 (
    .i_name        (i_rs1_name),
    .i_stored_data (r_data[i_rs1_name]),
    .i_stored_tag  (r_tag[i_rs1_name]),
    .i_commit_en   (i_commit_en),
    .i_commit_reg  (i_commit_reg),
    .i_commit_data (i_commit_data),
    .i_commit_tag  (i_commit_tag),
    .o_tag         (o_rs1_tag),
    .o_data        (o_rs1_data)
  );

  regfile_lookup u_lookup_rs2 (
    .i_name        (i_rs2_name),
    .i_stored_data (r_data[i_rs2_name]),
    .i_stored_tag  (r_tag[i_rs2_name]),
    .i_commit_en   (i_commit_en),
    .i_commit_reg  (i_commit_reg),
    .i_commit_data (i_commit_data),
    .i_commit_tag  (i_commit_tag),
    .o_tag         (o_rs2_tag),
    .o_data        (o_rs2_data)
  );

endmodule
